// File: rtl/vga_text_renderer_if.sv
// rtl/vga_text_renderer_if.sv - memory and video pin bundle for the text renderer
// Member names keep the renderer's point of view: _o are driven by the renderer, _i by the memories.
interface vga_text_renderer_if #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int COLOR_W  = 4
);
  localparam int ADDR_W  = $clog2((H_ACTIVE / CHAR_W) * (V_ACTIVE / CHAR_H));
  localparam int FONT_AW = 8 + $clog2(CHAR_H);

  logic [ADDR_W-1:0]  cell_addr_o;
  logic [15:0]        cell_data_i;
  logic [FONT_AW-1:0] font_addr_o;
  logic [CHAR_W-1:0]  font_data_i;
  logic [COLOR_W-1:0] red_o;
  logic [COLOR_W-1:0] green_o;
  logic [COLOR_W-1:0] blue_o;
  logic               hsync_o;
  logic               vsync_o;
  logic               frame_start_o;

  modport master (
    output cell_addr_o, font_addr_o, red_o, green_o, blue_o, hsync_o, vsync_o, frame_start_o,
    input  cell_data_i, font_data_i
  );

  modport slave (
    input  cell_addr_o, font_addr_o, red_o, green_o, blue_o, hsync_o, vsync_o, frame_start_o,
    output cell_data_i, font_data_i
  );
endinterface

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - text-mode VGA engine: timing, cell/font fetch, palette, blink, cursor
// Three-stage pipeline; all outputs land on the pins three clocks after the counter state they describe.
module vga_text_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 en_i,
  input  logic                                 cursor_en_i,
  input  logic [$clog2(H_ACTIVE/CHAR_W)-1:0]   cursor_col_i,
  input  logic [$clog2(V_ACTIVE/CHAR_H)-1:0]   cursor_row_i,
  vga_text_renderer_if.master                  bus
);

  localparam int N_COL   = H_ACTIVE / CHAR_W;
  localparam int N_ROW   = V_ACTIVE / CHAR_H;
  localparam int ADDR_W  = $clog2(N_COL * N_ROW);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int CW_L    = $clog2(CHAR_W);
  localparam int CH_L    = $clog2(CHAR_H);
  localparam int COL_W   = $clog2(N_COL);
  localparam int ROW_W   = $clog2(N_ROW);
  localparam int COLC_W  = HC_W - CW_L;
  localparam int ROWC_W  = VC_W - CH_L;
  localparam int BF_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [HC_W-1:0] HC_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_ACT    = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] VC_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VC_ACT_M1 = VC_W'(V_ACTIVE - 1);
  localparam logic [HC_W-1:0] HS_BEG    = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END    = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VS_BEG    = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END    = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CH_L-1:0] LINE_LAST = CH_L'(CHAR_H - 1);
  localparam logic [CH_L-1:0] CUR_LINE  = CH_L'(CHAR_H - 2);
  localparam logic [BF_W-1:0] BF_LAST   = BF_W'(BLINK_FRAMES - 1);
  localparam logic            HS_ACT    = (HS_POL != 0);
  localparam logic            VS_ACT    = (VS_POL != 0);

  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic [ADDR_W-1:0] row_base;
  logic [BF_W-1:0]   frame_cnt;
  logic              blink_on;
  logic              cur_en_q;
  logic [COL_W-1:0]  cur_col_q;
  logic [ROW_W-1:0]  cur_row_q;

  logic              h_last, v_last, h_act, v_act, act0, hs0, vs0, fs0, cur_hit0;
  logic [COLC_W-1:0] col0;
  logic [ROWC_W-1:0] row0;
  logic [CH_L-1:0]   line0;
  logic [CW_L-1:0]   px0;

  assign h_last = (hc == HC_LAST);
  assign v_last = (vc == VC_LAST);
  assign h_act  = (hc < HC_ACT);
  assign v_act  = (vc < VC_ACT);
  assign act0   = h_act && v_act;
  assign hs0    = (hc >= HS_BEG) && (hc < HS_END);
  assign vs0    = (vc >= VS_BEG) && (vc < VS_END);
  assign fs0    = (hc == '0) && (vc == '0);
  assign col0   = hc[HC_W-1:CW_L];
  assign row0   = vc[VC_W-1:CH_L];
  assign line0  = vc[CH_L-1:0];
  assign px0    = hc[CW_L-1:0];

  // Column term is zeroed in horizontal blanking so the address never leaves the buffer.
  assign bus.cell_addr_o = row_base + (h_act ? ADDR_W'(col0) : '0);

  assign cur_hit0 = cur_en_q && (col0 == COLC_W'(cur_col_q)) &&
                    (row0 == ROWC_W'(cur_row_q)) && (line0 >= CUR_LINE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc       <= '0;
      vc       <= '0;
      row_base <= '0;
    end else begin
      hc <= h_last ? '0 : hc + 1'b1;
      if (h_last) begin
        vc <= v_last ? '0 : vc + 1'b1;
        if (v_last)
          row_base <= '0;
        else if (line0 == LINE_LAST && vc < VC_ACT_M1)
          row_base <= row_base + ADDR_W'(N_COL);
      end
    end
  end

  // New blink phase and cursor take effect from the first pixel of a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      cur_en_q  <= 1'b0;
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else begin
      if (h_last && v_last) begin
        if (frame_cnt == BF_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      if (fs0) begin
        cur_en_q  <= cursor_en_i;
        cur_col_q <= cursor_col_i;
        cur_row_q <= cursor_row_i;
      end
    end
  end

  logic            s1_act, s1_en, s1_hs, s1_vs, s1_fs, s1_cur, s1_boff;
  logic [CH_L-1:0] s1_line;
  logic [CW_L-1:0] s1_px;
  logic            s2_act, s2_en, s2_hs, s2_vs, s2_fs, s2_cur, s2_bg_only;
  logic [CW_L-1:0] s2_px;
  logic [3:0]      s2_fg;
  logic [2:0]      s2_bg;
  logic            s3_hs, s3_vs, s3_fs;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  assign bus.font_addr_o = {bus.cell_data_i[7:0], s1_line};

  function automatic logic [COLOR_W-1:0] chan_lvl(input logic on, input logic inten);
    logic [COLOR_W-1:0] v;
    v = '0;
    if (on) begin
      v[COLOR_W-1] = 1'b1;
      if (inten) v = '1;
    end else if (inten) begin
      v[COLOR_W-2] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [3*COLOR_W-1:0] pal(input logic [3:0] idx);
    return {chan_lvl(idx[2], idx[3]), chan_lvl(idx[1], idx[3]), chan_lvl(idx[0], idx[3])};
  endfunction

  logic                 glyph_bit, fg_sel;
  logic [3*COLOR_W-1:0] rgb2;

  // CHAR_W is a power of two, so CHAR_W-1-px is just the bitwise complement of px.
  assign glyph_bit = bus.font_data_i[~s2_px];
  assign fg_sel    = s2_cur || (glyph_bit && !s2_bg_only);
  assign rgb2      = (s2_act && s2_en) ? (fg_sel ? pal(s2_fg) : pal({1'b0, s2_bg})) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_act     <= 1'b0;
      s1_en      <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_fs      <= 1'b0;
      s1_cur     <= 1'b0;
      s1_boff    <= 1'b0;
      s1_line    <= '0;
      s1_px      <= '0;
      s2_act     <= 1'b0;
      s2_en      <= 1'b0;
      s2_hs      <= 1'b0;
      s2_vs      <= 1'b0;
      s2_fs      <= 1'b0;
      s2_cur     <= 1'b0;
      s2_bg_only <= 1'b0;
      s2_px      <= '0;
      s2_fg      <= '0;
      s2_bg      <= '0;
      s3_hs      <= 1'b0;
      s3_vs      <= 1'b0;
      s3_fs      <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      s1_act     <= act0;
      s1_en      <= en_i;
      s1_hs      <= hs0;
      s1_vs      <= vs0;
      s1_fs      <= fs0;
      s1_cur     <= cur_hit0 && blink_on;
      s1_boff    <= !blink_on;
      s1_line    <= line0;
      s1_px      <= px0;
      s2_act     <= s1_act;
      s2_en      <= s1_en;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_fs      <= s1_fs;
      s2_cur     <= s1_cur;
      s2_bg_only <= s1_boff && bus.cell_data_i[15];
      s2_px      <= s1_px;
      s2_fg      <= bus.cell_data_i[11:8];
      s2_bg      <= bus.cell_data_i[14:12];
      s3_hs      <= s2_hs;
      s3_vs      <= s2_vs;
      s3_fs      <= s2_fs;
      {red_q, green_q, blue_q} <= rgb2;
    end
  end

  assign bus.red_o         = red_q;
  assign bus.green_o       = green_q;
  assign bus.blue_o        = blue_q;
  assign bus.hsync_o       = s3_hs ? HS_ACT : !HS_ACT;
  assign bus.vsync_o       = s3_vs ? VS_ACT : !VS_ACT;
  assign bus.frame_start_o = s3_fs;

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - randomized bench for vga_text_renderer with a frame-level reference model
// Small geometry keeps whole frames (and blink periods) cheap to simulate.
module tb_vga_text_renderer;

  localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 32, VFP = 1, VSW = 2, VBP = 1;
  localparam int HSP = 0, VSP = 1;
  localparam int CW = 8, CH = 8, CLW = 4, BF = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int NC = HA / CW, NR = VA / CH, NCELL = NC * NR;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cur_en;
  logic [1:0] cur_col;
  logic [1:0] cur_row;

  vga_text_renderer_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CHAR_W(CW), .CHAR_H(CH), .COLOR_W(CLW)) vif ();

  vga_text_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CHAR_W(CW), .CHAR_H(CH),
    .COLOR_W(CLW), .BLINK_FRAMES(BF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cursor_en_i(cur_en),
    .cursor_col_i(cur_col), .cursor_row_i(cur_row), .bus(vif)
  );

  always #5 clk = ~clk;

  logic [15:0]   screen [NCELL];
  logic [CW-1:0] font   [256*CH];

  always @(posedge clk) begin
    vif.cell_data_i <= screen[vif.cell_addr_o];
    vif.font_data_i <= font[vif.font_addr_o];
  end

  int passed = 0;
  int total  = 0;
  int k;
  logic en_hist [4];
  int cf_en, cf_col, cf_row;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, k, got, exp);
  endtask

  function automatic logic [CLW-1:0] lvl(input bit on, input bit inten);
    int v;
    if (on) v = inten ? (1 << CLW) - 1 : 1 << (CLW - 1);
    else    v = inten ? 1 << (CLW - 2) : 0;
    return CLW'(v);
  endfunction

  function automatic logic [3*CLW-1:0] pal(input logic [3:0] i);
    return {lvl(i[2], i[3]), lvl(i[1], i[3]), lvl(i[0], i[3])};
  endfunction

  // Expected {rgb, hsync, vsync, frame_start} for the n-th clock after reset release.
  function automatic logic [3*CLW+2:0] exp_pins(input int n);
    int p, fr, hc, vc, col, row, line;
    logic [15:0]   cw;
    logic [CW-1:0] g;
    logic          fgsel, phase_on, hs, vs, fs;
    logic [3*CLW-1:0] rgb;
    rgb = '0;
    if (n < 0) return {rgb, (HSP == 0), (VSP == 0), 1'b0};
    p  = n % FT;
    fr = n / FT;
    hc = p % HT;
    vc = p / HT;
    hs = (hc >= HA + HFP && hc < HA + HFP + HSW) ? (HSP != 0) : (HSP == 0);
    vs = (vc >= VA + VFP && vc < VA + VFP + VSW) ? (VSP != 0) : (VSP == 0);
    fs = (p == 0);
    if (hc < HA && vc < VA && en_hist[n % 4]) begin
      col      = hc / CW;
      row      = vc / CH;
      line     = vc % CH;
      cw       = screen[row * NC + col];
      g        = font[int'(cw[7:0]) * CH + line];
      fgsel    = g[CW - 1 - hc % CW];
      phase_on = ((fr / BF) % 2) == 0;
      if (cw[15] && !phase_on) fgsel = 1'b0;
      if (cf_en != 0 && col == cf_col && row == cf_row && line >= CH - 2 && phase_on) fgsel = 1'b1;
      rgb = fgsel ? pal(cw[11:8]) : pal({1'b0, cw[14:12]});
    end
    return {rgb, hs, vs, fs};
  endfunction

  task automatic note_inputs();
    en_hist[k % 4] = en;
    if (k % FT == 0) begin
      cf_en  = int'(cur_en);
      cf_col = int'(cur_col);
      cf_row = int'(cur_row);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"},   {vif.red_o, vif.green_o, vif.blue_o}, '0);
    check({tag, "_hsync"}, vif.hsync_o, (HSP == 0));
    check({tag, "_vsync"}, vif.vsync_o, (VSP == 0));
    check({tag, "_fs"},    vif.frame_start_o, 0);
    check({tag, "_addr"},  vif.cell_addr_o, 0);
  endtask

  task automatic step();
    int p, hc, vc;
    @(negedge clk);
    k++;
    p = k % FT;
    if (p == HT * VA + 5) begin
      cur_en  = ($urandom_range(0, 3) != 0);
      cur_col = 2'($urandom_range(0, NC - 1));
      cur_row = 2'($urandom_range(0, NR - 1));
    end
    if (en && $urandom_range(0, 399) == 0) en = 1'b0;
    else if (!en && $urandom_range(0, 39) == 0) en = 1'b1;
    note_inputs();
    check("pins", {vif.red_o, vif.green_o, vif.blue_o, vif.hsync_o, vif.vsync_o, vif.frame_start_o},
          exp_pins(k - 3));
    hc = p % HT;
    vc = p / HT;
    if (hc < HA && vc < VA)
      check("cell_addr", vif.cell_addr_o, (vc / CH) * NC + hc / CW);
    else
      check("addr_range", (vif.cell_addr_o < NCELL), 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    note_inputs();
  endtask

  initial begin
    for (int i = 0; i < NCELL; i++) screen[i] = 16'($urandom);
    for (int i = 0; i < 256 * CH; i++) font[i] = CW'($urandom);
    screen[0]  = 16'h0F41;
    font[8'h41 * CH] = 8'b1000_0001;
    screen[NCELL - 1] = 16'h1220;
    screen[2 * NC + 1] = 16'h0C20;
    screen[5]  = 16'h9ADB;
    for (int l = 0; l < CH; l++) begin
      font[8'h20 * CH + l] = '0;
      font[8'hDB * CH + l] = '1;
    end

    k = 0;
    rst = 1'b1;
    en = 1'b1;
    cur_en = 1'b1;
    cur_col = 2'd1;
    cur_row = 2'd2;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    release_reset();
    for (int i = 0; i < FT * 8 + 3; i++) step();

    for (int i = 0; i < FT && (k % FT) != HT * 10 + 12; i++) step();
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    check_reset_values("held_reset");

    release_reset();
    for (int i = 0; i < FT * 4; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
